// File: rtl/enc_pwm_pkg.sv
// enc_pwm_pkg: shared defaults and saturate/wrap mode encoding for enc_pwm_mixer
package enc_pwm_pkg;
  localparam int NCH_DEF = 3;
  localparam int PWM_W_DEF = 8;
  localparam int DEB_CYC_DEF = 8;
  localparam int STEP_DEF = 1;
  typedef enum logic {MODE_WRAP = 1'b0, MODE_SAT = 1'b1} sat_mode_e;
endpackage

// File: rtl/enc_channel.sv
// enc_channel: one quadrature channel - synchroniser, debounce, A-rise decode, level register
// Ports: clk, reset (sync, active-high); a/b raw encoder pins; sat_mode (1 = clamp, 0 = wrap);
//        load/load_value preset (wins over a same-cycle step); level current channel level.
module enc_channel import enc_pwm_pkg::*; #(
  parameter int PWM_W = PWM_W_DEF,
  parameter int DEB_CYC = DEB_CYC_DEF,
  parameter int STEP = STEP_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a,
  input  logic             b,
  input  logic             sat_mode,
  input  logic             load,
  input  logic [PWM_W-1:0] load_value,
  output logic [PWM_W-1:0] level
);
  localparam logic [PWM_W:0] ST = (PWM_W+1)'(STEP);
  // bit 0 carries pin A, bit 1 carries pin B
  logic [1:0] s1, s2, deb, deb_q;
  logic [1:0][7:0] cnt;
  logic up, dn;
  logic [PWM_W:0] inc, dec;
  logic [PWM_W-1:0] nxt;
  always_comb begin
    inc = {1'b0, level} + ST;
    dec = {1'b0, level} - ST;
    nxt = load ? load_value
        : up ? ((sat_mode == MODE_SAT && inc[PWM_W]) ? '1 : inc[PWM_W-1:0])
        : dn ? ((sat_mode == MODE_SAT && dec[PWM_W]) ? '0 : dec[PWM_W-1:0])
        : level;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
      deb <= '0;
      deb_q <= '0;
      cnt <= '0;
      up <= 1'b0;
      dn <= 1'b0;
      level <= '0;
    end else begin
      s1 <= {b, a};
      s2 <= s1;
      // any cycle where the synchronised pin agrees with the accepted value restarts the run
      for (int p = 0; p < 2; p++) begin
        if (s2[p] == deb[p]) cnt[p] <= '0;
        else if (cnt[p] == 8'(DEB_CYC - 1)) begin
          deb[p] <= s2[p];
          cnt[p] <= '0;
        end else cnt[p] <= cnt[p] + 8'd1;
      end
      deb_q <= deb;
      up <= deb[0] & ~deb_q[0] & ~deb[1];
      dn <= deb[0] & ~deb_q[0] & deb[1];
      level <= nxt;
    end
  end
endmodule

// File: rtl/enc_pwm_mixer.sv
// enc_pwm_mixer: NCH quadrature-driven levels feeding NCH PWM outputs from one shared counter
// Ports: clk, reset (sync, active-high); enc_a/enc_b raw encoder pins; sat_mode clamp/wrap select;
//        load_valid/load_ch/load_value level preset; pwm_out registered PWM; level_out packed levels.
module enc_pwm_mixer import enc_pwm_pkg::*; #(
  parameter int NCH = NCH_DEF,
  parameter int PWM_W = PWM_W_DEF,
  parameter int DEB_CYC = DEB_CYC_DEF,
  parameter int STEP = STEP_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NCH-1:0]       enc_a,
  input  logic [NCH-1:0]       enc_b,
  input  logic                 sat_mode,
  input  logic                 load_valid,
  input  logic [2:0]           load_ch,
  input  logic [PWM_W-1:0]     load_value,
  output logic [NCH-1:0]       pwm_out,
  output logic [NCH*PWM_W-1:0] level_out
);
  logic [PWM_W-1:0] cnt;
  genvar i;
  generate
    for (i = 0; i < NCH; i++) begin : g_ch
      // out-of-range load_ch matches no channel, so such loads fall away
      enc_channel #(.PWM_W(PWM_W), .DEB_CYC(DEB_CYC), .STEP(STEP)) u_ch (
        .clk(clk),
        .reset(reset),
        .a(enc_a[i]),
        .b(enc_b[i]),
        .sat_mode(sat_mode),
        .load(load_valid && load_ch == 3'(i)),
        .load_value(load_value),
        .level(level_out[i*PWM_W +: PWM_W])
      );
    end
  endgenerate
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      pwm_out <= '0;
    end else begin
      cnt <= cnt + 1'b1;
      for (int k = 0; k < NCH; k++) pwm_out[k] <= cnt < level_out[k*PWM_W +: PWM_W];
    end
  end
endmodule

// File: doc/enc_pwm_mixer.md
ENC_PWM_MIXER -- requirements
Module: enc_pwm_mixer

Interface
REQ-001 Parameter NCH, default 3: number of encoder/PWM channels, 1..8.
REQ-002 Parameter PWM_W, default 8: level and PWM counter width, 4..12.
REQ-003 Parameter DEB_CYC, default 8: consecutive stable cycles needed to accept an encoder pin change, 2..255.
REQ-004 Parameter STEP, default 1: level change per detent, 1..2^(PWM_W-1).
REQ-005 Port clk  in  1  single clock for all logic.
REQ-006 Port reset  in  1  synchronous, active-high reset.
REQ-007 Port enc_a  in  NCH  quadrature A pins, asynchronous.
REQ-008 Port enc_b  in  NCH  quadrature B pins, asynchronous.
REQ-009 Port sat_mode  in  1  1 = saturate levels at 0/max, 0 = wrap modulo 2^PWM_W.
REQ-010 Port load_valid  in  1  one-cycle strobe to preset a level.
REQ-011 Port load_ch  in  3  target channel of the preset.
REQ-012 Port load_value  in  PWM_W  preset level.
REQ-013 Port pwm_out  out  NCH  registered PWM outputs.
REQ-014 Port level_out  out  NCH*PWM_W  current levels, channel i at bits [i*PWM_W +: PWM_W].

Function
REQ-015 Each enc_a/enc_b bit SHALL pass a 2-flop synchroniser before any other use.
REQ-016 Each synchronised pin SHALL have a debounced value that changes only after the synchronised input has differed from it for DEB_CYC consecutive cycles; any intermediate match SHALL restart the count.
REQ-017 On a debounced A rising edge, the channel SHALL step up by STEP if debounced B is 0, and down by STEP if debounced B is 1; all other edges SHALL be ignored.
REQ-018 The level register SHALL update in the cycle after the debounced A edge is registered; pin-to-level latency SHALL be exactly DEB_CYC+4 cycles from the first cycle the new pin value is sampled.
REQ-019 With sat_mode=1, up-steps SHALL clamp at 2^PWM_W-1 and down-steps SHALL clamp at 0.
REQ-020 With sat_mode=0, arithmetic SHALL be modulo 2^PWM_W (255+1 -> 0, 0-1 -> 255 for PWM_W=8, STEP=1).
REQ-021 load_valid=1 with load_ch<NCH SHALL set that level to load_value on the next cycle; load_ch>=NCH SHALL be ignored.
REQ-022 A load and an encoder step on the same channel in the same cycle SHALL resolve with the load taking effect and the step discarded.
REQ-023 One free-running PWM_W-bit counter SHALL be shared by all channels, incrementing every cycle and wrapping at 2^PWM_W-1 -> 0.
REQ-024 pwm_out[i] SHALL be registered (counter < level[i]); level 0 gives constant low, level L gives exactly L high cycles per 2^PWM_W-cycle period.
REQ-025 A level change SHALL take effect on pwm_out at the next counter compare, with no frame buffering.
REQ-026 Channels SHALL be fully independent; simultaneous steps on different channels SHALL all apply.

Reset
REQ-027 During reset, all levels, the PWM counter, debounce counters and synchroniser flops SHALL clear to 0, and debounced values SHALL be 0.
REQ-028 pwm_out and level_out SHALL be 0 in the cycle after reset is sampled high.
REQ-029 Reset asserted mid-debounce or mid-step SHALL discard the pending event; no step SHALL occur on the first cycle after reset release.

Structure
REQ-030 Package enc_pwm_pkg SHALL hold default parameter constants and the sat/wrap mode encoding.
REQ-031 Sub-module enc_channel (synchroniser, debounce, decode, level register) SHALL be instantiated NCH times via generate; the PWM counter and compare logic SHALL stay in the top level.

Verification
REQ-032 Defaults; hold B=0, pulse A high for 20 cycles -> level[0] 0->1 exactly DEB_CYC+4 cycles after A rises.
REQ-033 A glitch of 5 cycles (< DEB_CYC) on enc_a[1] -> level[1] stays 0.
REQ-034 sat_mode=1, load ch2=254, two up-steps -> level 255, 255; sat_mode=0, one more up-step -> level 0.
REQ-035 Load ch0=64, run 512 cycles -> pwm_out[0] high exactly 64 of every 256 cycles; level 0 -> never high.
REQ-036 Load on ch1 coincident with a step on ch1 and a step on ch0 -> ch1 = load_value, ch0 stepped; load_ch=5 with NCH=3 -> no change.
REQ-037 Reset asserted at DEB_CYC-1 of a pending debounce -> all outputs 0 next cycle, no step after release.
